// File: rtl/ram_boot_loader_pkg.sv
// Shared types and constants for the RAM boot loader: FSM state encoding and
// stream framing sizes (2 length bytes, 4 bytes per little-endian word).
package ram_boot_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN0  = 3'd1,
        ST_LEN1  = 3'd2,
        ST_DATA  = 3'd3,
        ST_WRITE = 3'd4,
        ST_CHK   = 3'd5,
        ST_DONE  = 3'd6,
        ST_ERR   = 3'd7
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_BYTES      = 2;

endpackage

// File: rtl/ram_boot_loader_byte_word_packer.sv
// Packs accepted stream bytes little-endian into a 32-bit word. o_word_valid
// pulses with the last byte's acceptance; o_word holds the full word from the next cycle.
module byte_word_packer
    import ram_boot_loader_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clear,
    input  logic        i_accept,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_valid
);

    localparam int IDX_W = $clog2(BYTES_PER_WORD);

    logic [IDX_W-1:0] r_idx;
    logic [31:0]      r_word;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idx  <= '0;
            r_word <= '0;
        end else if (i_clear) begin
            r_idx  <= '0;
        end else if (i_accept) begin
            for (int k = 0; k < BYTES_PER_WORD; k++) begin
                if (r_idx == IDX_W'(k)) r_word[8*k +: 8] <= i_byte;
            end
            // Index wraps naturally back to byte 0 after the last lane.
            r_idx <= r_idx + 1'b1;
        end
    end

    assign o_word       = r_word;
    assign o_word_valid = i_accept && (r_idx == IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/ram_boot_loader.sv
// Boot loader: streams a length-prefixed image into RAM, muxing the RAM port
// between CPU and loader. Optional trailing checksum byte: RAM_BOOT_LOADER_CHECKSUM_EN.
module ram_boot_loader
    import ram_boot_loader_pkg::*;
#(
    parameter int ADDR_W    = 14,
    parameter int MAX_WORDS = 8192,
    parameter int BASE_ADDR = 0
)
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    // Byte handshake: a byte moves on a rising edge where i_byte_valid && o_byte_ready;
    // o_byte_ready depends only on state, never on i_byte_valid.
    input  logic              i_byte_valid,
    input  logic [7:0]        i_byte_data,
    output logic              o_byte_ready,
    input  logic [ADDR_W-1:0] i_cpu_address,
    input  logic              i_cpu_mem_write,
    input  logic [31:0]       i_cpu_write_data,
    output logic [ADDR_W-1:0] o_address,
    output logic              o_mem_write,
    output logic [31:0]       o_write_data,
    output logic              o_cpu_stall,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error,
    output logic [ADDR_W:0]   o_word_count,
    output state_t            o_state
);

    state_t          r_state, w_next;
    logic [15:0]     r_len;
    logic [ADDR_W:0] r_word_count;
    logic            r_done, r_error;

    logic            w_byte_ready, w_xfer, w_busy;
    logic            w_start_load, w_set_done, w_set_err;
    logic            w_word_valid, w_last_word;
    logic [31:0]     w_word;
    logic [15:0]     w_len_full;
    logic [ADDR_W:0] w_count_inc;
    logic [ADDR_W-1:0] w_load_addr;

    assign w_byte_ready = (r_state == ST_LEN0) || (r_state == ST_LEN1) ||
                          (r_state == ST_DATA) || (r_state == ST_CHK);
    assign w_busy       = w_byte_ready || (r_state == ST_WRITE);
    assign w_xfer       = i_byte_valid && w_byte_ready;
    assign w_len_full   = {i_byte_data, r_len[7:0]};
    assign w_count_inc  = r_word_count + 1'b1;
    assign w_last_word  = (32'(w_count_inc) == 32'(r_len));
    assign w_load_addr  = ADDR_W'(BASE_ADDR) + r_word_count[ADDR_W-1:0];

`ifdef RAM_BOOT_LOADER_CHECKSUM_EN
    logic [7:0] r_sum;
    logic [7:0] w_sum_next;
    assign w_sum_next = r_sum + i_byte_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                          r_sum <= '0;
        else if (w_start_load)                 r_sum <= '0;
        else if (w_xfer && r_state != ST_CHK)  r_sum <= w_sum_next;
    end
`endif

    byte_word_packer u_packer (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_clear      (w_start_load),
        .i_accept     (w_xfer && (r_state == ST_DATA)),
        .i_byte       (i_byte_data),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    always_comb begin
        w_next       = r_state;
        w_start_load = 1'b0;
        w_set_done   = 1'b0;
        w_set_err    = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (i_start) begin
                    w_next       = ST_LEN0;
                    w_start_load = 1'b1;
                end
            end
            ST_LEN0: if (w_xfer) w_next = ST_LEN1;
            ST_LEN1: begin
                if (w_xfer) begin
                    if (w_len_full == 16'd0) begin
                        w_next     = ST_DONE;
                        w_set_done = 1'b1;
                    end else if (32'(w_len_full) > $unsigned(MAX_WORDS)) begin
                        w_next    = ST_ERR;
                        w_set_err = 1'b1;
                    end else begin
                        w_next = ST_DATA;
                    end
                end
            end
            ST_DATA: if (w_word_valid) w_next = ST_WRITE;
            ST_WRITE: begin
                if (w_last_word) begin
`ifdef RAM_BOOT_LOADER_CHECKSUM_EN
                    w_next = ST_CHK;
`else
                    w_next     = ST_DONE;
                    w_set_done = 1'b1;
`endif
                end else begin
                    w_next = ST_DATA;
                end
            end
            ST_CHK: begin
`ifdef RAM_BOOT_LOADER_CHECKSUM_EN
                if (w_xfer) begin
                    if (w_sum_next == 8'h00) begin
                        w_next     = ST_DONE;
                        w_set_done = 1'b1;
                    end else begin
                        w_next    = ST_ERR;
                        w_set_err = 1'b1;
                    end
                end
`else
                w_next = ST_IDLE;
`endif
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_len        <= '0;
            r_word_count <= '0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start_load) begin
                r_len        <= '0;
                r_word_count <= '0;
                r_done       <= 1'b0;
                r_error      <= 1'b0;
            end else begin
                if (w_set_done) r_done  <= 1'b1;
                if (w_set_err)  r_error <= 1'b1;
                if (w_xfer && r_state == ST_LEN0) r_len[7:0]  <= i_byte_data;
                if (w_xfer && r_state == ST_LEN1) r_len[15:8] <= i_byte_data;
                if (r_state == ST_WRITE) r_word_count <= w_count_inc;
            end
        end
    end

    // While busy the CPU is fully cut off from the RAM, including its writes.
    always_comb begin
        if (w_busy) begin
            o_address    = w_load_addr;
            o_mem_write  = (r_state == ST_WRITE);
            o_write_data = w_word;
        end else begin
            o_address    = i_cpu_address;
            o_mem_write  = i_cpu_mem_write;
            o_write_data = i_cpu_write_data;
        end
    end

    assign o_byte_ready = w_byte_ready;
    assign o_busy       = w_busy;
    assign o_cpu_stall  = w_busy;
    assign o_done       = r_done;
    assign o_error      = r_error;
    assign o_word_count = r_word_count;
    assign o_state      = r_state;

endmodule

// File: tb/tb_ram_boot_loader.sv
// Directed bench for ram_boot_loader with a behavioural RAM, a write scoreboard
// and hand-computed expectations; checksum vectors apply when RAM_BOOT_LOADER_CHECKSUM_EN is set.
module tb_ram_boot_loader;
  import ram_boot_loader_pkg::*;

  localparam int ADDR_W = 14;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = 8'h00;
  logic              byte_ready;
  logic [ADDR_W-1:0] cpu_address = '0;
  logic              cpu_mem_write = 1'b0;
  logic [31:0]       cpu_write_data = '0;
  logic [ADDR_W-1:0] address;
  logic              mem_write;
  logic [31:0]       write_data;
  logic              cpu_stall, busy, done, error;
  logic [ADDR_W:0]   word_count;
  state_t            state;

  logic [31:0]       ram [0:(1<<ADDR_W)-1];
  logic [31:0]       exp_q[$];
  logic [31:0]       exp_addr_q[$];
  logic [7:0]        sum_acc = 8'h00;
  int                n_vec = 0;
  int                n_err = 0;
  int                we_cycles = 0;
  int                we_pulses = 0;
  logic              we_prev = 1'b0;
  int                wc0, wp0;

  ram_boot_loader dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_start          (start),
    .i_byte_valid     (byte_valid),
    .i_byte_data      (byte_data),
    .o_byte_ready     (byte_ready),
    .i_cpu_address    (cpu_address),
    .i_cpu_mem_write  (cpu_mem_write),
    .i_cpu_write_data (cpu_write_data),
    .o_address        (address),
    .o_mem_write      (mem_write),
    .o_write_data     (write_data),
    .o_cpu_stall      (cpu_stall),
    .o_busy           (busy),
    .o_done           (done),
    .o_error          (error),
    .o_word_count     (word_count),
    .o_state          (state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // behavioural RAM
  always @(posedge clk) begin
    if (mem_write) ram[address] <= write_data;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // scoreboard on loader writes
  always @(negedge clk) begin
    if (cpu_stall && mem_write) begin
      we_cycles++;
      if (!we_prev) we_pulses++;
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_write", 32'(exp_q.size()), 32'd1);
      end else begin
        chk("sb_word", write_data, exp_q.pop_front());
        chk("sb_addr", 32'(address), exp_addr_q.pop_front());
      end
    end
    we_prev = cpu_stall && mem_write;
  end

  // driver tasks
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    sum_acc = 8'h00;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!byte_ready) chk("byte_ready_timeout", 32'(byte_ready), 32'd1);
    @(negedge clk);
    byte_valid = 1'b0;
    sum_acc = sum_acc + b;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("busy_timeout", 32'(busy), 32'd0);
  endtask

  task automatic end_image();
`ifdef RAM_BOOT_LOADER_CHECKSUM_EN
    logic [7:0] c;
    c = 8'h00 - sum_acc;
    send_byte(c);
`endif
    wait_idle();
  endtask

  task automatic expect_word(input logic [31:0] addr, input logic [31:0] w);
    exp_q.push_back(w);
    exp_addr_q.push_back(addr);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_state", 32'(state), 32'(ST_IDLE));
    chk("rst_byte_ready", 32'(byte_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_word_count", 32'(word_count), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // idle passthrough
    cpu_address = 14'd5; cpu_mem_write = 1'b1; cpu_write_data = 32'h1111_1111;
    #1;
    chk("pass_addr", 32'(address), 32'd5);
    chk("pass_we", 32'(mem_write), 32'd1);
    chk("pass_data", write_data, 32'h1111_1111);
    @(negedge clk);
    cpu_mem_write = 1'b0;
    chk("pass_ram5", ram[5], 32'h1111_1111);

    // two-word image, continuous stream
    wc0 = we_cycles; wp0 = we_pulses;
    expect_word(0, 32'h1234_5678);
    expect_word(1, 32'hDEAD_BEEF);
    pulse_start();
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_stall", 32'(cpu_stall), 32'd1);
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    end_image();
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_error", 32'(error), 32'd0);
    chk("t1_word_count", 32'(word_count), 32'd2);
    chk("t1_stall_after", 32'(cpu_stall), 32'd0);
    chk("t1_ram0", ram[0], 32'h1234_5678);
    chk("t1_ram1", ram[1], 32'hDEAD_BEEF);
    chk("t1_we_cycles", 32'(we_cycles - wc0), 32'd2);
    chk("t1_we_pulses", 32'(we_pulses - wp0), 32'd2);

    // zero-length image
    wc0 = we_cycles;
    pulse_start();
    chk("t2_done_cleared", 32'(done), 32'd0);
    send_byte(8'h00); send_byte(8'h00);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_state", 32'(state), 32'(ST_DONE));
    chk("t2_busy", 32'(busy), 32'd0);
    chk("t2_word_count", 32'(word_count), 32'd0);
    chk("t2_no_write", 32'(we_cycles - wc0), 32'd0);

    // oversize length 8193
    pulse_start();
    send_byte(8'h01); send_byte(8'h20);
    chk("t3_error", 32'(error), 32'd1);
    chk("t3_done", 32'(done), 32'd0);
    chk("t3_byte_ready", 32'(byte_ready), 32'd0);
    chk("t3_state", 32'(state), 32'(ST_ERR));
    chk("t3_no_write", 32'(we_cycles - wc0), 32'd0);
    expect_word(0, 32'hCAFE_F00D);
    pulse_start();
    chk("t3_error_cleared", 32'(error), 32'd0);
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h0D); send_byte(8'hF0); send_byte(8'hFE); send_byte(8'hCA);
    end_image();
    chk("t3_done_retry", 32'(done), 32'd1);
    chk("t3_ram0", ram[0], 32'hCAFE_F00D);
    chk("t3_word_count", 32'(word_count), 32'd1);

    // CPU write held during a load is dropped, then lands once idle
    expect_word(0, 32'h0000_ABCD);
    pulse_start();
    cpu_address = 14'd5; cpu_mem_write = 1'b1; cpu_write_data = 32'hFFFF_FFFF;
    #1;
    chk("t4_stall", 32'(cpu_stall), 32'd1);
    chk("t4_we_blocked", 32'(mem_write), 32'd0);
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hCD); send_byte(8'hAB); send_byte(8'h00); send_byte(8'h00);
    end_image();
    chk("t4_ram5_kept", ram[5], 32'h1111_1111);
    chk("t4_done", 32'(done), 32'd1);
    @(negedge clk);
    cpu_mem_write = 1'b0;
    chk("t4_ram5_cpu", ram[5], 32'hFFFF_FFFF);
    chk("t4_ram0", ram[0], 32'h0000_ABCD);

    // reset in the middle of a word
    pulse_start();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'hAA); send_byte(8'hBB);
    chk("t5_pre_state", 32'(state), 32'(ST_DATA));
    rst_n = 1'b0;
    #1;
    chk("t5_state", 32'(state), 32'(ST_IDLE));
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_stall", 32'(cpu_stall), 32'd0);
    chk("t5_byte_ready", 32'(byte_ready), 32'd0);
    chk("t5_word_count", 32'(word_count), 32'd0);
    chk("t5_mem_write", 32'(mem_write), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    expect_word(0, 32'h7FFF_FFFF);
    pulse_start();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h7F);
    end_image();
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_ram0", ram[0], 32'h7FFF_FFFF);

`ifdef RAM_BOOT_LOADER_CHECKSUM_EN
    // checksum: bytes sum to 0x02, so FE closes to zero and FF does not
    expect_word(0, 32'h0000_0001);
    pulse_start();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'hFE);
    chk("t6_good_done", 32'(done), 32'd1);
    chk("t6_good_error", 32'(error), 32'd0);
    cpu_address = 14'd0; cpu_mem_write = 1'b1; cpu_write_data = 32'h0;
    @(negedge clk);
    cpu_mem_write = 1'b0;
    expect_word(0, 32'h0000_0001);
    pulse_start();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'hFF);
    chk("t6_bad_error", 32'(error), 32'd1);
    chk("t6_bad_done", 32'(done), 32'd0);
    chk("t6_bad_ram0", ram[0], 32'h0000_0001);
`endif

    repeat (2) @(negedge clk);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
